// File: rtl/ahb_pkg.sv
// ----------------------------------------------------------------------------
// ahb_pkg
//   Shared AHB-Lite definitions for the response-side slave multiplexer.
//   - HTRANS encodings and HRESP codes
//   - Default-slave state enum (DF_IDLE / DF_ERR1 / DF_ERR2)
//   - Port count and error-counter width
// ----------------------------------------------------------------------------
package ahb_pkg;

    localparam int NUM_PORTS = 5;
    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DF_IDLE = 2'b00,
        DF_ERR1 = 2'b01,
        DF_ERR2 = 2'b10
    } dflt_state_t;

endpackage

// File: rtl/ahblite_default_slave.sv
// ----------------------------------------------------------------------------
// ahblite_default_slave
//   Built-in default slave: answers active transfers (NONSEQ/SEQ) that hit no
//   enabled slave with the standard two-cycle AHB ERROR response, and answers
//   IDLE/BUSY or an idle bus with a zero-wait OKAY.
//
//   Optional feature macro: AHB_MUX_ERR_CNT_EN
//     defined   -> ERR_CNT counts entries into DF_ERR1, saturating at all-ones
//     undefined -> ERR_CNT tied to zero, no counter logic
//
// Ports:
//   HCLK       in   bus clock
//   HRESET     in   synchronous active-high reset
//   HREADY     in   bus HREADY; qualifies the address phase
//   HTRANS     in   master transfer type
//   any_sel    in   some enabled slave is selected by the current address
//   HREADYOUT  out  default slave ready
//   HRESP      out  default slave response
//   ERR_CNT    out  error-response counter (zero when feature disabled)
// ----------------------------------------------------------------------------
module ahblite_default_slave
    import ahb_pkg::*;
(
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HREADY,
    input  logic [1:0]           HTRANS,
    input  logic                 any_sel,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    dflt_state_t r_state;
    dflt_state_t w_next;
    logic        w_active;
    logic        w_capture_err;

    assign w_active      = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign w_capture_err = HREADY && !any_sel && w_active;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= DF_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next    = r_state;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (r_state)
            DF_IDLE: begin
                if (HREADY) begin
                    w_next = w_capture_err ? DF_ERR1 : DF_IDLE;
                end
            end
            DF_ERR1: begin
                // First ERROR cycle stalls the bus, so no address is captured.
                w_next    = DF_ERR2;
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            DF_ERR2: begin
                // The address phase overlapping the second ERROR cycle is
                // captured normally and may itself be unmapped.
                if (HREADY) begin
                    w_next = w_capture_err ? DF_ERR1 : DF_IDLE;
                end
                HRESP = HRESP_ERROR;
            end
            default: begin
                w_next = DF_IDLE;
            end
        endcase
    end

`ifdef AHB_MUX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic                 w_enter_err;

    assign w_enter_err = (w_next == DF_ERR1) && (r_state != DF_ERR1);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_err_cnt <= '0;
        end else if (w_enter_err && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    assign ERR_CNT = r_err_cnt;
`else
    assign ERR_CNT = '0;
`endif

endmodule

// File: rtl/ahblite_slave_mux.sv
// ----------------------------------------------------------------------------
// ahblite_slave_mux
//   AHB-Lite response-side multiplexer for five slave ports (RAMCODE, RAMDATA,
//   GCD, Segdisp, Keyboard). The decoder selects are registered in the address
//   phase; during the data phase the selected slave's HRDATA/HREADYOUT/HRESP
//   are steered combinationally to the master. Unmapped or disabled regions
//   are answered by the built-in default slave. Only the select is registered,
//   so no latency is added to the data path.
//
//   Optional feature macro: AHB_MUX_ERR_CNT_EN (default-slave error counter)
//
// Parameters:
//   PORT0_EN..PORT4_EN  1 = port present; 0 = its HSEL is ignored and the
//                       region answers as unmapped
// Ports:
//   HCLK, HRESET                       clock, synchronous active-high reset
//   HREADY                             bus HREADY (HREADYOUT fed back)
//   HTRANS                             master transfer type
//   HSEL_P0..HSEL_P4                   decoder selects
//   P0..P4 _HRDATA/_HREADYOUT/_HRESP   slave responses
//   HRDATA, HREADYOUT, HRESP           muxed response to the master
//   ERR_CNT                            default-slave error count
// ----------------------------------------------------------------------------
module ahblite_slave_mux
    import ahb_pkg::*;
#(
    parameter int PORT0_EN = 1,
    parameter int PORT1_EN = 1,
    parameter int PORT2_EN = 1,
    parameter int PORT3_EN = 1,
    parameter int PORT4_EN = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HREADY,
    input  logic [1:0]           HTRANS,
    input  logic                 HSEL_P0,
    input  logic                 HSEL_P1,
    input  logic                 HSEL_P2,
    input  logic                 HSEL_P3,
    input  logic                 HSEL_P4,
    input  logic [31:0]          P0_HRDATA,
    input  logic [31:0]          P1_HRDATA,
    input  logic [31:0]          P2_HRDATA,
    input  logic [31:0]          P3_HRDATA,
    input  logic [31:0]          P4_HRDATA,
    input  logic                 P0_HREADYOUT,
    input  logic                 P1_HREADYOUT,
    input  logic                 P2_HREADYOUT,
    input  logic                 P3_HREADYOUT,
    input  logic                 P4_HREADYOUT,
    input  logic                 P0_HRESP,
    input  logic                 P1_HRESP,
    input  logic                 P2_HRESP,
    input  logic                 P3_HRESP,
    input  logic                 P4_HRESP,
    output logic [31:0]          HRDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    localparam logic [NUM_PORTS-1:0] PORT_EN_MASK = {
        (PORT4_EN != 0), (PORT3_EN != 0), (PORT2_EN != 0),
        (PORT1_EN != 0), (PORT0_EN != 0)
    };

    logic [NUM_PORTS-1:0] r_sel_q;
    logic [NUM_PORTS-1:0] w_hsel;
    logic                 w_any_sel;
    logic                 w_df_hreadyout;
    logic                 w_df_hresp;
    logic [31:0]          w_rdata  [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_ready;
    logic [NUM_PORTS-1:0] w_resp;

    // Disabled ports are masked here so they fall through to the default slave.
    assign w_hsel    = {HSEL_P4, HSEL_P3, HSEL_P2, HSEL_P1, HSEL_P0} & PORT_EN_MASK;
    assign w_any_sel = |w_hsel;

    assign w_rdata[0] = P0_HRDATA;
    assign w_rdata[1] = P1_HRDATA;
    assign w_rdata[2] = P2_HRDATA;
    assign w_rdata[3] = P3_HRDATA;
    assign w_rdata[4] = P4_HRDATA;
    assign w_ready    = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign w_resp     = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};

    // Select is captured only when the bus is ready, so a wait-stated data
    // phase keeps steering from the same slave.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_sel_q <= '0;
        end else if (HREADY) begin
            r_sel_q <= w_hsel;
        end
    end

    ahblite_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HREADY    (HREADY),
        .HTRANS    (HTRANS),
        .any_sel   (w_any_sel),
        .HREADYOUT (w_df_hreadyout),
        .HRESP     (w_df_hresp),
        .ERR_CNT   (ERR_CNT)
    );

    // Scanning from the highest index down lets the lowest set bit be the
    // last assignment, so an illegal multi-hot decode resolves to it.
    always_comb begin
        HRDATA    = '0;
        HREADYOUT = w_df_hreadyout;
        HRESP     = w_df_hresp;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (r_sel_q[i]) begin
                HRDATA    = w_rdata[i];
                HREADYOUT = w_ready[i];
                HRESP     = w_resp[i];
            end
        end
    end

endmodule

// File: tb/tb_ahblite_slave_mux.sv
// ----------------------------------------------------------------------------
// tb_ahblite_slave_mux
//   Two mux instances share one stimulus stream: d0 has every port enabled,
//   d1 has port 2 (GCD) disabled. Each instance has its own HREADY feedback.
//   A transfer-level reference model (data-phase owner + ERROR-cycle index)
//   predicts every response.
// ----------------------------------------------------------------------------
module tb_ahblite_slave_mux;

    logic        HCLK = 1'b0;
    logic        rst;
    logic [1:0]  htrans;
    logic [4:0]  hsel;
    logic [31:0] p_rdata [5];
    logic        p_ready [5];
    logic        p_resp  [5];

    logic [31:0] hrdata_o [2];
    logic        hready_o [2];
    logic        hresp_o  [2];
    logic [15:0] cnt_o    [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state per instance
    int m_owner [2];   // index of slave owning the data phase, -1 if none
    int m_err   [2];   // 0 = no error, 1 = first ERROR cycle, 2 = second
    int m_cnt   [2];

    always #5 HCLK = ~HCLK;

    ahblite_slave_mux dut0 (
        .HCLK(HCLK), .HRESET(rst), .HREADY(hready_o[0]), .HTRANS(htrans),
        .HSEL_P0(hsel[0]), .HSEL_P1(hsel[1]), .HSEL_P2(hsel[2]),
        .HSEL_P3(hsel[3]), .HSEL_P4(hsel[4]),
        .P0_HRDATA(p_rdata[0]), .P1_HRDATA(p_rdata[1]), .P2_HRDATA(p_rdata[2]),
        .P3_HRDATA(p_rdata[3]), .P4_HRDATA(p_rdata[4]),
        .P0_HREADYOUT(p_ready[0]), .P1_HREADYOUT(p_ready[1]), .P2_HREADYOUT(p_ready[2]),
        .P3_HREADYOUT(p_ready[3]), .P4_HREADYOUT(p_ready[4]),
        .P0_HRESP(p_resp[0]), .P1_HRESP(p_resp[1]), .P2_HRESP(p_resp[2]),
        .P3_HRESP(p_resp[3]), .P4_HRESP(p_resp[4]),
        .HRDATA(hrdata_o[0]), .HREADYOUT(hready_o[0]), .HRESP(hresp_o[0]),
        .ERR_CNT(cnt_o[0])
    );

    ahblite_slave_mux #(.PORT2_EN(0)) dut1 (
        .HCLK(HCLK), .HRESET(rst), .HREADY(hready_o[1]), .HTRANS(htrans),
        .HSEL_P0(hsel[0]), .HSEL_P1(hsel[1]), .HSEL_P2(hsel[2]),
        .HSEL_P3(hsel[3]), .HSEL_P4(hsel[4]),
        .P0_HRDATA(p_rdata[0]), .P1_HRDATA(p_rdata[1]), .P2_HRDATA(p_rdata[2]),
        .P3_HRDATA(p_rdata[3]), .P4_HRDATA(p_rdata[4]),
        .P0_HREADYOUT(p_ready[0]), .P1_HREADYOUT(p_ready[1]), .P2_HREADYOUT(p_ready[2]),
        .P3_HREADYOUT(p_ready[3]), .P4_HREADYOUT(p_ready[4]),
        .P0_HRESP(p_resp[0]), .P1_HRESP(p_resp[1]), .P2_HRESP(p_resp[2]),
        .P3_HRESP(p_resp[3]), .P4_HRESP(p_resp[4]),
        .HRDATA(hrdata_o[1]), .HREADYOUT(hready_o[1]), .HRESP(hresp_o[1]),
        .ERR_CNT(cnt_o[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] en_mask(input int d);
        return (d == 0) ? 5'b11111 : 5'b11011;
    endfunction

    function automatic int lowest(input logic [4:0] v);
        for (int i = 0; i < 5; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic exp_ready(input int d);
        if (m_owner[d] >= 0) return p_ready[m_owner[d]];
        return (m_err[d] != 1);
    endfunction

    function automatic logic exp_resp(input int d);
        if (m_owner[d] >= 0) return p_resp[m_owner[d]];
        return (m_err[d] != 0);
    endfunction

    function automatic logic [31:0] exp_data(input int d);
        if (m_owner[d] >= 0) return p_rdata[m_owner[d]];
        return 32'h0;
    endfunction

    function automatic logic [15:0] exp_cnt(input int d);
`ifdef AHB_MUX_ERR_CNT_EN
        return m_cnt[d][15:0];
`else
        return 16'h0 + 16'(d - d);
`endif
    endfunction

    task automatic model_tick(input int d, input logic rdy);
        logic [4:0] masked;
        if (rst) begin
            m_owner[d] = -1;
            m_err[d]   = 0;
            m_cnt[d]   = 0;
        end else if (m_err[d] == 1) begin
            m_err[d] = 2;
        end else if (rdy) begin
            masked     = hsel & en_mask(d);
            m_owner[d] = lowest(masked);
            if (masked == 5'b0 && htrans[1]) begin
                m_err[d] = 1;
                if (m_cnt[d] < 65535) m_cnt[d]++;
            end else begin
                m_err[d] = 0;
            end
        end
    endtask

    // ---------------- cycle helpers ----------------
    task automatic sample();
        @(negedge HCLK);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d.hrdata", d), hrdata_o[d], exp_data(d));
            check($sformatf("d%0d.hreadyout", d), {31'b0, hready_o[d]}, {31'b0, exp_ready(d)});
            check($sformatf("d%0d.hresp", d), {31'b0, hresp_o[d]}, {31'b0, exp_resp(d)});
            check($sformatf("d%0d.err_cnt", d), {16'b0, cnt_o[d]}, {16'b0, exp_cnt(d)});
        end
    endtask

    task automatic tick();
        logic r0, r1;
        r0 = exp_ready(0);
        r1 = exp_ready(1);
        @(posedge HCLK);
        model_tick(0, r0);
        model_tick(1, r1);
        #1;
    endtask

    task automatic set_idle_bus();
        htrans = 2'b00;
        hsel   = 5'b0;
        for (int i = 0; i < 5; i++) begin
            p_rdata[i] = $urandom;
            p_ready[i] = 1'b1;
            p_resp[i]  = 1'b0;
        end
    endtask

    task automatic randomize_inputs();
        int r;
        htrans = 2'($urandom_range(0, 3));
        r = $urandom_range(0, 9);
        if (r < 2)      hsel = 5'b0;
        else if (r < 9) hsel = 5'b1 << $urandom_range(0, 4);
        else            hsel = 5'($urandom);
        for (int i = 0; i < 5; i++) begin
            p_rdata[i] = $urandom;
            p_ready[i] = ($urandom_range(0, 3) != 0);
            p_resp[i]  = ($urandom_range(0, 7) == 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1;
            m_err[d]   = 0;
            m_cnt[d]   = 0;
        end

        // Reset for two cycles with random inputs
        rst = 1'b1;
        randomize_inputs();
        tick();
        randomize_inputs();
        tick();
        sample();
        check("rst.hreadyout", {31'b0, hready_o[0]}, 32'd1);
        check("rst.hresp", {31'b0, hresp_o[0]}, 32'd0);
        check("rst.hrdata", hrdata_o[0], 32'h0);
        check("rst.err_cnt", {16'b0, cnt_o[0]}, 32'd0);
        rst = 1'b0;
        set_idle_bus();
        tick();

        // NONSEQ to P1 with two wait states
        htrans = 2'b10; hsel = 5'b00010;
        sample(); tick();
        htrans = 2'b00; hsel = 5'b0;
        p_rdata[1] = 32'hDEADBEEF; p_ready[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sample();
            check("p1.wait_ready", {31'b0, hready_o[0]}, 32'd0);
            check("p1.wait_data", hrdata_o[0], 32'hDEADBEEF);
            tick();
        end
        p_ready[1] = 1'b1;
        sample();
        check("p1.done_ready", {31'b0, hready_o[0]}, 32'd1);
        check("p1.done_resp", {31'b0, hresp_o[0]}, 32'd0);
        tick();

        // Unmapped NONSEQ: two-cycle ERROR
        set_idle_bus();
        htrans = 2'b10;
        sample(); tick();
        htrans = 2'b00;
        sample();
        check("unmap.err1_ready", {31'b0, hready_o[0]}, 32'd0);
        check("unmap.err1_resp", {31'b0, hresp_o[0]}, 32'd1);
        tick();
        sample();
        check("unmap.err2_ready", {31'b0, hready_o[0]}, 32'd1);
        check("unmap.err2_resp", {31'b0, hresp_o[0]}, 32'd1);
        tick();

        // Disabled port 2: d1 errors, d0 passes P2 data
        set_idle_bus();
        htrans = 2'b10; hsel = 5'b00100;
        sample(); tick();
        htrans = 2'b00; hsel = 5'b0; p_rdata[2] = 32'hCAFEF00D;
        sample();
        check("p2off.err1_ready", {31'b0, hready_o[1]}, 32'd0);
        check("p2off.err1_data", hrdata_o[1], 32'h0);
        check("p2on.data", hrdata_o[0], 32'hCAFEF00D);
        tick();
        sample();
        check("p2off.err2_resp", {31'b0, hresp_o[1]}, 32'd1);
        check("p2off.err2_data", hrdata_o[1], 32'h0);
        tick();

        // Back-to-back: unmapped, then P3 captured during the second ERROR cycle
        set_idle_bus();
        htrans = 2'b10;
        sample(); tick();
        hsel = 5'b01000;
        sample(); tick();
        sample(); tick();
        htrans = 2'b00; hsel = 5'b0; p_rdata[3] = 32'h12345678;
        sample();
        check("b2b.p3_data", hrdata_o[0], 32'h12345678);
        check("b2b.p3_ready", {31'b0, hready_o[0]}, 32'd1);
        check("b2b.p3_resp", {31'b0, hresp_o[0]}, 32'd0);
        tick();
        sample();
        check("idle.okay_ready", {31'b0, hready_o[0]}, 32'd1);
        check("idle.okay_resp", {31'b0, hresp_o[0]}, 32'd0);
        tick();

        // Reset while in DF_ERR1
        htrans = 2'b11;
        sample(); tick();
        htrans = 2'b00; rst = 1'b1;
        sample(); tick();
        rst = 1'b0;
        sample();
        check("rst_err1.ready", {31'b0, hready_o[0]}, 32'd1);
        check("rst_err1.resp", {31'b0, hresp_o[0]}, 32'd0);
        check("rst_err1.cnt", {16'b0, cnt_o[0]}, 32'd0);
        tick();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 199) == 0);
            sample();
            tick();
        end
        rst = 1'b0;

`ifdef AHB_MUX_ERR_CNT_EN
        // Saturation: continuous unmapped NONSEQ traffic
        set_idle_bus();
        htrans = 2'b10;
        begin
            int budget;
            budget = 0;
            while (m_cnt[0] < 65535 && budget < 140000) begin
                tick();
                budget++;
            end
            check("sat.budget", {31'b0, (budget >= 140000)}, 32'd0);
            for (int k = 0; k < 8; k++) tick();
        end
        sample();
        check("sat.cnt0", {16'b0, cnt_o[0]}, 32'h0000FFFF);
        check("sat.cnt1", {16'b0, cnt_o[1]}, 32'h0000FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
